// File: rtl/ecc_gf7_pkg.sv
// Shared GF(2^7) definitions for the ECC datapath: field constants, curve defaults,
// compressed-point layout and reduced field arithmetic helpers.
package ecc_gf7_pkg;

   localparam int                GF_W      = 7;
   localparam logic [GF_W:0]     GF_POLY   = 8'h83;
   localparam logic [GF_W-1:0]   GF_A_DEF  = 7'h01;
   localparam logic [GF_W-1:0]   GF_B_DEF  = 7'h01;
   localparam logic [2*GF_W-1:0] PT_INF    = 14'h0;
   localparam int                CP_X_LSB  = 0;
   localparam int                CP_YBIT   = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INV,
      ST_RHS,
      ST_HTR,
      ST_FIN,
      ST_OUT
   } dec_state_t;

   // Shift-and-add multiply with reduction on every shift.
   function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a, input logic [GF_W-1:0] b);
      logic [GF_W-1:0] p;
      logic [GF_W-1:0] s;
      p = '0;
      s = a;
      for (int i = 0; i < GF_W; i++) begin
         if (b[i]) p = p ^ s;
         s = s[GF_W-1] ? ({s[GF_W-2:0], 1'b0} ^ GF_POLY[GF_W-1:0]) : {s[GF_W-2:0], 1'b0};
      end
      return p;
   endfunction

   // Square root via the Frobenius map: b^(2^6) since squaring has order 7.
   function automatic logic [GF_W-1:0] gf_sqrt(input logic [GF_W-1:0] b);
      logic [GF_W-1:0] v;
      v = b;
      for (int i = 0; i < GF_W - 1; i++) v = gf_mul(v, v);
      return v;
   endfunction

endpackage

// File: rtl/Mastrovito7.sv
// Combinational GF(2^7) multiplier, reduction by x^7 + x + 1.
module Mastrovito7
   import ecc_gf7_pkg::*;
(
   input  logic [GF_W-1:0] i_a,
   input  logic [GF_W-1:0] i_b,
   output logic [GF_W-1:0] o_p
);

   assign o_p = gf_mul(i_a, i_b);

endmodule

// File: rtl/Squarer.sv
// Combinational GF(2^7) squarer; squaring is linear, so it is a fixed XOR network.
module Squarer
   import ecc_gf7_pkg::*;
(
   input  logic [GF_W-1:0] i_a,
   output logic [GF_W-1:0] o_s
);

   // a4..a6 spill past x^6 and fold back through x^7 = x + 1.
   assign o_s = {i_a[3] ^ i_a[6], i_a[6], i_a[2] ^ i_a[5], i_a[5],
                 i_a[1] ^ i_a[4], i_a[4], i_a[0]};

endmodule

// File: rtl/point_decompressor.sv
// Decompresses {ybit, x} into affine {y, x} on y^2 + xy = x^3 + A x^2 + B over GF(2^7),
// sharing one multiplier across the inversion, right-hand-side and final product steps.
module point_decompressor
   import ecc_gf7_pkg::*;
#(
   parameter logic [GF_W-1:0] A = GF_A_DEF,
   parameter logic [GF_W-1:0] B = GF_B_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [GF_W:0]       in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*GF_W-1:0]   out_data,
   output logic                out_err
);

   localparam logic [GF_W-1:0] SQRT_B = gf_sqrt(B);

   dec_state_t        r_state;
   logic [2:0]        r_cnt;
   logic              r_ybit;
   logic [GF_W-1:0]   r_x, r_r, r_xinv, r_c, r_h, r_t;
   logic              r_in_ready, r_out_valid, r_out_err;
   logic [2*GF_W-1:0] r_out_data;

   logic [GF_W-1:0]   w_sq_in, w_sq_out, w_t2, w_t4;
   logic [GF_W-1:0]   w_mul_a, w_mul_b, w_mul_p, w_z, w_c_next;

   // z = h with bit 0 forced to the requested ybit, selecting between the two roots.
   assign w_z      = {r_h[GF_W-1:1], r_ybit};
   assign w_c_next = r_x ^ A ^ w_mul_p;

   always_comb begin
      w_sq_in = r_r;
      w_mul_a = w_sq_out;
      w_mul_b = r_x;
      case (r_state)
         ST_RHS: begin
            w_sq_in = r_xinv;
            w_mul_a = B;
            w_mul_b = w_sq_out;
         end
         ST_FIN: begin
            w_sq_in = r_h;
            w_mul_a = r_x;
            w_mul_b = w_z;
         end
         default: ;
      endcase
   end

   Mastrovito7 u_mul   (.i_a(w_mul_a), .i_b(w_mul_b), .o_p(w_mul_p));
   Squarer     u_sq    (.i_a(w_sq_in), .o_s(w_sq_out));
   Squarer     u_sq_t1 (.i_a(r_t),     .o_s(w_t2));
   Squarer     u_sq_t2 (.i_a(w_t2),    .o_s(w_t4));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_ybit      <= 1'b0;
         r_x         <= '0;
         r_r         <= '0;
         r_xinv      <= '0;
         r_c         <= '0;
         r_h         <= '0;
         r_t         <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
         r_out_data  <= PT_INF;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_in_ready <= 1'b0;
                  r_x        <= in_data[CP_X_LSB +: GF_W];
                  r_ybit     <= in_data[CP_YBIT];
                  if (in_data[CP_X_LSB +: GF_W] == '0) begin
                     r_out_err   <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_data  <= in_data[CP_YBIT] ? {SQRT_B, {GF_W{1'b0}}} : PT_INF;
                     r_state     <= ST_OUT;
                  end else begin
                     r_r     <= in_data[CP_X_LSB +: GF_W];
                     r_cnt   <= '0;
                     r_state <= ST_INV;
                  end
               end
            end
            // x^-1 = x^126 by repeated r <= r^2 * x, then one final squaring.
            ST_INV: begin
               if (r_cnt == 3'd5) begin
                  r_xinv  <= w_sq_out;
                  r_state <= ST_RHS;
               end else begin
                  r_r   <= w_mul_p;
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            ST_RHS: begin
               r_c     <= w_c_next;
               r_h     <= w_c_next;
               r_t     <= w_c_next;
               r_cnt   <= '0;
               r_state <= ST_HTR;
            end
            // Half-trace c + c^4 + c^16 + c^64 solves z^2 + z = c when trace(c) = 0.
            ST_HTR: begin
               r_t <= w_t4;
               r_h <= r_h ^ w_t4;
               if (r_cnt == 3'd2) r_state <= ST_FIN;
               else               r_cnt   <= r_cnt + 3'd1;
            end
            ST_FIN: begin
               if ((w_sq_out ^ r_h) != r_c) begin
                  r_out_err  <= 1'b1;
                  r_out_data <= PT_INF;
               end else begin
                  r_out_err  <= 1'b0;
                  r_out_data <= {w_mul_p, r_x};
               end
               r_out_valid <= 1'b1;
               r_state     <= ST_OUT;
            end
            ST_OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_err   = r_out_err;

endmodule

// File: tb/tb_point_decompressor.sv
// Directed and exhaustive-x bench for point_decompressor with default curve A = B = 1.
module tb_point_decompressor;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [13:0] out_data;
   logic        out_err;

   int n_chk;
   int n_bad;

   point_decompressor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference field multiply: full carry-less product, then reduce from the top bit down.
   function automatic logic [6:0] m_mul(input logic [6:0] a, input logic [6:0] b);
      logic [12:0] p;
      p = '0;
      for (int i = 0; i < 7; i++) if (b[i]) p = p ^ (13'(a) << i);
      for (int k = 12; k >= 7; k--) if (p[k]) p = p ^ (13'h83 << (k - 7));
      return p[6:0];
   endfunction

   // Returns latency as edges counted from the acceptance edge inclusive.
   task automatic decode(input logic [7:0] d, output logic [13:0] od, output logic oe, output int lat);
      int n;
      in_data  = d;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      od = out_data;
      oe = out_err;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   logic [13:0] od;
   logic        oe;
   int          lat;

   initial begin
      n_chk = 0;
      n_bad = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_err", 32'(out_err), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      decode(8'h02, od, oe, lat);
      chk("x02_data", 32'(od), 32'h2E02);
      chk("x02_err", 32'(oe), 32'd0);
      chk("x02_lat", 32'(lat), 32'd12);

      decode(8'h82, od, oe, lat);
      chk("x82_data", 32'(od), 32'h2F02);
      chk("x82_err", 32'(oe), 32'd0);

      decode(8'h01, od, oe, lat);
      chk("x01_data", 32'(od), 32'h0000);
      chk("x01_err", 32'(oe), 32'd1);

      decode(8'h00, od, oe, lat);
      chk("inf_data", 32'(od), 32'h0000);
      chk("inf_err", 32'(oe), 32'd0);
      chk("inf_lat", 32'(lat), 32'd1);

      decode(8'h80, od, oe, lat);
      chk("sqrtb_data", 32'(od), 32'h0080);
      chk("sqrtb_err", 32'(oe), 32'd0);
      chk("sqrtb_lat", 32'(lat), 32'd1);

      // Backpressure with in_valid held high throughout.
      in_data = 8'h82;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_data = 8'h02;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_data", 32'(out_data), 32'h2F02);
         chk("bp_hold_ready", 32'(in_ready), 32'd0);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_drop_valid", 32'(out_valid), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_accept", 32'(in_ready), 32'd0);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("bp_next_data", 32'(out_data), 32'h2E02);
      chk("bp_next_lat", 32'(lat), 32'd12);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset asserted while the half-trace is running.
      in_data = 8'h02;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_data", 32'(out_data), 32'h0);
      chk("abort_out_err", 32'(out_err), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      lat = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (out_valid) lat++;
      end
      chk("abort_no_output", 32'(lat), 32'd0);
      decode(8'h02, od, oe, lat);
      chk("post_abort_data", 32'(od), 32'h2E02);
      chk("post_abort_err", 32'(oe), 32'd0);

      // Every nonzero x with both ybit values against a brute-force curve solver.
      for (int x = 1; x < 128; x++) begin
         logic [6:0] xv, xi, rhs, yy, zz, ey;
         logic       found;
         xv = 7'(x);
         xi = '0;
         for (int v = 1; v < 128; v++) if (m_mul(xv, 7'(v)) == 7'h01) xi = 7'(v);
         rhs = m_mul(m_mul(xv, xv), xv) ^ m_mul(xv, xv) ^ 7'h01;
         for (int yb = 0; yb < 2; yb++) begin
            found = 1'b0;
            ey = '0;
            for (int y = 0; y < 128; y++) begin
               yy = 7'(y);
               zz = m_mul(yy, xi);
               if (!found && ((m_mul(yy, yy) ^ m_mul(xv, yy)) == rhs) && (zz[0] == yb[0])) begin
                  found = 1'b1;
                  ey = yy;
               end
            end
            decode({yb[0], xv}, od, oe, lat);
            chk($sformatf("rt_data_%0h_%0d", xv, yb), 32'(od), found ? 32'({ey, xv}) : 32'h0);
            chk($sformatf("rt_err_%0h_%0d", xv, yb), 32'(oe), found ? 32'd0 : 32'd1);
            chk($sformatf("rt_lat_%0h_%0d", xv, yb), 32'(lat), 32'd12);
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/point_decompressor.md
Name: point_decompressor

Overview:
Decodes an 8-bit compressed elliptic-curve point {ybit, x} into the 14-bit affine form {y[6:0], x[6:0]} used by the point adder, doubler and multiplier. The curve is y^2 + x*y = x^3 + A*x^2 + B over GF(2^7), with field polynomial x^7 + x + 1. The block is the receive-side counterpart of point compression and sits between the key/ciphertext input path and PointMultiplier. It is a multi-cycle FSM that time-shares one field multiplier, with valid/ready handshakes on both sides.

Parameters:
A, 7'h01, curve coefficient a; must match PointAdder/PointDouble (which hardwire a = 1).
B, 7'h01, curve coefficient b.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  compressed point present on in_data
in_ready  out  1  block can accept a point
in_data  in  8  [7] = ybit (LSB of y/x), [6:0] = x
out_valid  out  1  decoded result present; held until out_ready
out_ready  in  1  consumer accepts the result
out_data  out  14  {y, x}; 14'h0 for infinity or on error
out_err  out  1  x is not a valid curve abscissa; qualified by out_valid

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State goes to IDLE.
  - in_ready = 1, out_valid = 0, out_data = 0, out_err = 0.
  - All working registers clear.
  - Assertion mid-operation aborts the operation; no output is produced.
- States: IDLE, INV, RHS, HTR, FIN, OUT.
- IDLE:
  - in_ready = 1. in_ready is 1 only in IDLE.
  - On in_valid & in_ready, latch in_data.
  - in_data == 8'h00: next state OUT with out_data = 0 (infinity), out_err = 0.
  - in_data == 8'h80: next state OUT with out_data = {sqrtB, 7'h00}, where sqrtB = B^(2^6), a constant derived from B.
  - Any other x == 0 input is not possible (the two codes above cover x = 0).
  - Otherwise, next state INV with r = x.
- INV, 6 cycles:
  - Cycles 1 to 5: r <= r^2 * x, producing x^3, x^7, ..., x^63.
  - Cycle 6: xinv <= r^2, i.e. x^126 = x^-1.
- RHS, 1 cycle: c <= x ^ A ^ (B * xinv^2).
- HTR, 3 cycles:
  - Initialise h = c, t = c.
  - Each cycle: t <= t^4 (two chained squarers), h <= h ^ t.
  - Result is the half-trace H(c).
- FIN, 1 cycle:
  - z = h, flipped in bit 0 if h[0] != ybit.
  - If h^2 ^ h != c (trace(c) = 1): out_err <= 1, out_data <= 0.
  - Else: out_data <= {x * z, x}.
- OUT:
  - out_valid = 1; out_data and out_err are stable.
  - On out_ready, go to IDLE and drop out_valid.
  - in_ready returns the next cycle; no bypass and no overlap.
- Latency from the acceptance edge to out_valid:
  - General path: 12 edges (INV 6 + RHS 1 + HTR 3 + FIN 1 + entry 1).
  - 8'h00 and 8'h80 paths: 1 edge.
- Throughput: one point per (latency + 1) cycles with out_ready held high.
- Arithmetic: all GF(2^7) (XOR add, reduced multiply/square); no integer carries anywhere.
- out_data and out_err change only on the FIN or IDLE transitions; they are held in OUT regardless of in_valid.

Decomposition:
- Shared package ecc_gf7_pkg:
  - field width 7, polynomial 8'h83
  - default A and B
  - infinity code 14'h0
  - compressed-point field offsets
  - constant function for sqrtB (six squarings)
- Instantiate the existing Mastrovito7 once, with operands muxed by state:
  - INV: r^2, x
  - RHS: B, xinv^2
  - FIN: x, z
- Instantiate the existing Squarer three times: the r/xinv/h check squarer and the two chained squarers in HTR.
- No new sub-module.

Test Plan:
- Reset default (A = B = 1): in_data = 8'h02, ybit = 0 -> after 12 cycles out_valid = 1, out_data = 14'h2E02, out_err = 0.
- in_data = 8'h82 -> out_data = 14'h2F02 (y = 0x5E), out_err = 0.
- in_data = 8'h01 (x = 1, c = 1, trace 1) -> out_err = 1, out_data = 14'h0000. in_data = 8'h00 -> out_data = 0, out_err = 0 after 1 cycle.
- in_data = 8'h80 -> out_data = 14'h0080 after 1 cycle.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid held high -> out_data stable, in_ready = 0 throughout; out_ready pulse -> in_ready = 1 next cycle and the next point is accepted.
- Drop rst_n during HTR -> outputs at reset values immediately, no out_valid. Then 8'h02 -> 14'h2E02. Round trip: random on-curve points from PointMultiplier, compressed by the bench, decode bit-exact.
